// File: rtl/motor_drive_core.sv
// Multi-channel H-bridge PWM driver with ramped duty, reversal dead time
// and latched overcurrent fault per channel.
//
// Ports:
//   CLK_100MHz    in   system clock, rising edge
//   RST_N         in   synchronous active-low reset
//   duty_cmd      in   commanded duty, channel i at [i*DUTY_W +: DUTY_W]
//   dir_cmd       in   commanded direction (0 fwd, 1 rev)
//   over_set      in   async overcurrent trip comparator
//   under_reset   in   async recovery comparator
//   motor_fwd     out  forward leg drive (registered)
//   motor_rev     out  reverse leg drive (registered)
//   fault         out  channel is in FAULT
//   duty_eff      out  applied (ramped) duty
//   dir_act       out  applied direction
//   period_strobe out  last clock of each PWM period
module motor_drive_core #(
    parameter int CHANNELS  = 2,
    parameter int DUTY_W    = 7,
    parameter int PRESCALE  = 1000,
    parameter int DEADTIME  = 50,
    parameter int RAMP_STEP = 1
) (
    input  logic                         CLK_100MHz,
    input  logic                         RST_N,
    input  logic [CHANNELS*DUTY_W-1:0]   duty_cmd,
    input  logic [CHANNELS-1:0]          dir_cmd,
    input  logic [CHANNELS-1:0]          over_set,
    input  logic [CHANNELS-1:0]          under_reset,
    output logic [CHANNELS-1:0]          motor_fwd,
    output logic [CHANNELS-1:0]          motor_rev,
    output logic [CHANNELS-1:0]          fault,
    output logic [CHANNELS*DUTY_W-1:0]   duty_eff,
    output logic [CHANNELS-1:0]          dir_act,
    output logic                         period_strobe
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int DW = $clog2(DEADTIME + 1);
    localparam int STEP_C = (RAMP_STEP > (1 << DUTY_W)) ? (1 << DUTY_W) : RAMP_STEP;

    localparam logic [PW-1:0]     PRE_MAX = PW'(PRESCALE - 1);
    localparam logic [DUTY_W-1:0] CNT_MAX = '1;
    localparam logic [DW-1:0]     DEAD_LD = DW'(DEADTIME);
    localparam logic [DUTY_W:0]   STEP_W  = (DUTY_W + 1)'(STEP_C);

    typedef enum logic [1:0] {RUN, STOP, DEAD, FAULT} state_e;

    logic [PW-1:0]     presc_q;
    logic [DUTY_W-1:0] cnt_q;
    logic              tick;
    logic [CHANNELS-1:0] ovr_s1_q, ovr_s2_q;
    logic [CHANNELS-1:0] und_s1_q, und_s2_q;

    assign tick          = (presc_q == PRE_MAX);
    assign period_strobe = tick && (cnt_q == CNT_MAX);

    // Shared timebase: prescaler tick and free-running PWM counter.
    always_ff @(posedge CLK_100MHz) begin
        if (!RST_N) begin
            presc_q <= '0;
            cnt_q   <= '0;
        end else begin
            presc_q <= tick ? '0 : presc_q + PW'(1);
            if (tick) cnt_q <= cnt_q + DUTY_W'(1);
        end
    end

    always_ff @(posedge CLK_100MHz) begin
        if (!RST_N) begin
            ovr_s1_q <= '0;
            ovr_s2_q <= '0;
            und_s1_q <= '0;
            und_s2_q <= '0;
        end else begin
            ovr_s1_q <= over_set;
            ovr_s2_q <= ovr_s1_q;
            und_s1_q <= under_reset;
            und_s2_q <= und_s1_q;
        end
    end

    genvar i;
    for (i = 0; i < CHANNELS; i++) begin : g_ch
        state_e            state_q;
        logic [DUTY_W-1:0] eff_q;
        logic [DUTY_W-1:0] eff_d;
        logic [DUTY_W-1:0] target;
        logic [DUTY_W:0]   t_w, e_w, nxt_w;
        logic [DW-1:0]     dead_q;
        logic              dir_q, fwd_q, rev_q, drive;

        // One ramp step toward target, clamped so it never overshoots.
        always_comb begin
            target = (state_q == RUN) ? duty_cmd[i*DUTY_W +: DUTY_W] : '0;
            t_w    = {1'b0, target};
            e_w    = {1'b0, eff_q};
            if (t_w >= e_w + STEP_W)      nxt_w = e_w + STEP_W;
            else if (t_w > e_w)           nxt_w = t_w;
            else if (e_w >= t_w + STEP_W) nxt_w = e_w - STEP_W;
            else                          nxt_w = t_w;
            eff_d = nxt_w[DUTY_W-1:0];
        end

        assign drive = (cnt_q < eff_q) &&
                       ((state_q == RUN) || (state_q == STOP));

        always_ff @(posedge CLK_100MHz) begin
            if (!RST_N) begin
                state_q <= RUN;
                eff_q   <= '0;
                dead_q  <= '0;
                dir_q   <= 1'b0;
                fwd_q   <= 1'b0;
                rev_q   <= 1'b0;
            end else begin
                fwd_q <= drive & ~dir_q;
                rev_q <= drive & dir_q;
                if (ovr_s2_q[i]) begin
                    state_q <= FAULT;
                    eff_q   <= '0;
                end else begin
                    case (state_q)
                        RUN: begin
                            if (period_strobe) eff_q <= eff_d;
                            if (dir_cmd[i] != dir_q) state_q <= STOP;
                        end
                        STOP: begin
                            if (period_strobe) begin
                                if (eff_q == '0) begin
                                    state_q <= DEAD;
                                    dead_q  <= DEAD_LD;
                                end else begin
                                    eff_q <= eff_d;
                                end
                            end
                        end
                        DEAD: begin
                            // Last counted tick leaves DEAD, so the
                            // state lasts exactly DEADTIME ticks.
                            if (tick) begin
                                if (dead_q <= DW'(1)) begin
                                    state_q <= RUN;
                                    dir_q   <= dir_cmd[i];
                                end else begin
                                    dead_q <= dead_q - DW'(1);
                                end
                            end
                        end
                        FAULT: begin
                            if (und_s2_q[i]) begin
                                state_q <= DEAD;
                                dead_q  <= DEAD_LD;
                            end
                        end
                        default: state_q <= RUN;
                    endcase
                end
            end
        end

        assign motor_fwd[i]                 = fwd_q;
        assign motor_rev[i]                 = rev_q;
        assign fault[i]                     = (state_q == FAULT);
        assign dir_act[i]                   = dir_q;
        assign duty_eff[i*DUTY_W +: DUTY_W] = eff_q;
    end

endmodule
